// File: rtl/mem_byte_seq.sv
// mem_byte_seq
// Two-port word-access sequencer for the byte-wide on-chip memory.
// Requests from two masters (port 0 instruction fetch, port 1 load/store)
// are arbitrated round-robin. Each granted 32-bit request is broken into
// one memory cycle per selected byte lane, most significant lane first
// (big-endian: sel[3] -> byte offset 0).
//
// Ports
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_mX_cyc/adr/we/sel/dat request from master X (held until ack)
//   o_mX_dat, o_mX_ack      read data and one-cycle completion pulse
//   o_mem_en/we/adr/dat     byte port towards the memory array
//   i_mem_dat               read byte, valid one cycle after an enabled read
//
// state  | meaning
// S_IDLE | waiting for a request; arbitrate and latch it
// S_XFER | issue one selected byte lane per cycle
// S_LAST | memory idle; capture the final read byte
// S_ACK  | pulse ack to the granted port, update round-robin pointer
module mem_byte_seq #(
  parameter int AW = 14
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m0_cyc,
  input  logic [AW-1:0] i_m0_adr,
  input  logic          i_m0_we,
  input  logic [3:0]    i_m0_sel,
  input  logic [31:0]   i_m0_dat,
  output logic [31:0]   o_m0_dat,
  output logic          o_m0_ack,
  input  logic          i_m1_cyc,
  input  logic [AW-1:0] i_m1_adr,
  input  logic          i_m1_we,
  input  logic [3:0]    i_m1_sel,
  input  logic [31:0]   i_m1_dat,
  output logic [31:0]   o_m1_dat,
  output logic          o_m1_ack,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_adr,
  output logic [7:0]    o_mem_dat,
  input  logic [7:0]    i_mem_dat
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_ACK} state_t;

  state_t        r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic          r_we;
  logic [3:0]    r_sel_rem;
  logic [31:0]   r_wdat;
  logic [AW-1:0] r_base;
  logic [31:0]   r_rd_data;
  logic          r_cap_vld;
  logic [1:0]    r_cap_lane;
  logic          r_m0_ack;
  logic          r_m1_ack;

  logic          w_grant_nxt;
  logic [AW-1:0] w_req_adr;
  logic          w_req_we;
  logic [3:0]    w_req_sel;
  logic [31:0]   w_req_dat;
  logic [1:0]    w_lane;
  logic [1:0]    w_off;
  logic [3:0]    w_sel_after;
  logic          w_in_xfer;
  logic [7:0]    w_wbyte;

  // Port 1 wins when it is the only requester, or on a tie when port 0
  // was served last.
  assign w_grant_nxt = i_m1_cyc & (~i_m0_cyc | ~r_last_grant);

  assign w_req_adr = w_grant_nxt ? i_m1_adr : i_m0_adr;
  assign w_req_we  = w_grant_nxt ? i_m1_we  : i_m0_we;
  assign w_req_sel = w_grant_nxt ? i_m1_sel : i_m0_sel;
  assign w_req_dat = w_grant_nxt ? i_m1_dat : i_m0_dat;

  // Highest remaining lane goes first.
  always_comb begin
    w_lane = 2'd0;
    if (r_sel_rem[3])      w_lane = 2'd3;
    else if (r_sel_rem[2]) w_lane = 2'd2;
    else if (r_sel_rem[1]) w_lane = 2'd1;
  end

  assign w_off       = 2'd3 - w_lane;
  assign w_sel_after = r_sel_rem & ~(4'b0001 << w_lane);
  assign w_wbyte     = 8'(r_wdat >> {w_lane, 3'b000});
  assign w_in_xfer   = (r_state == S_XFER);

  assign o_mem_en  = w_in_xfer;
  assign o_mem_we  = w_in_xfer & r_we;
  assign o_mem_adr = w_in_xfer ? (r_base + {{(AW-2){1'b0}}, w_off}) : '0;
  assign o_mem_dat = w_in_xfer ? w_wbyte : 8'h00;

  assign o_m0_dat = r_rd_data;
  assign o_m1_dat = r_rd_data;
  assign o_m0_ack = r_m0_ack;
  assign o_m1_ack = r_m1_ack;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_sel_rem    <= 4'b0000;
      r_wdat       <= 32'h0;
      r_base       <= '0;
      r_rd_data    <= 32'h0;
      r_cap_vld    <= 1'b0;
      r_cap_lane   <= 2'd0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
    end else begin
      // A lane read in the previous cycle returns its byte now.
      r_cap_vld <= 1'b0;
      if (r_cap_vld) begin
        r_rd_data[{r_cap_lane, 3'b000} +: 8] <= i_mem_dat;
      end

      case (r_state)
        S_IDLE: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          if (i_m0_cyc | i_m1_cyc) begin
            r_grant   <= w_grant_nxt;
            r_we      <= w_req_we;
            r_sel_rem <= w_req_sel;
            r_wdat    <= w_req_dat;
            r_base    <= w_req_adr & ~{{(AW-2){1'b0}}, 2'b11};
            r_rd_data <= 32'h0;
            r_state   <= (w_req_sel == 4'b0000) ? S_LAST : S_XFER;
          end
        end
        S_XFER: begin
          r_sel_rem  <= w_sel_after;
          r_cap_vld  <= ~r_we;
          r_cap_lane <= w_lane;
          if (w_sel_after == 4'b0000) begin
            r_state <= S_LAST;
          end
        end
        S_LAST: begin
          r_m0_ack <= ~r_grant;
          r_m1_ack <= r_grant;
          r_state  <= S_ACK;
        end
        S_ACK: begin
          r_m0_ack     <= 1'b0;
          r_m1_ack     <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_seq.sv
// tb_mem_byte_seq
// Directed bench for mem_byte_seq with a behavioural 16 KB byte memory.
// A shadow copy of the memory predicts read data; expected memory cycles
// and read words are queued when a request is driven and popped as the
// DUT produces them.
module tb_mem_byte_seq;
  localparam int AW = 14;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic          we;
    logic [7:0]    dat;
  } mem_op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m1_cyc;
  logic [AW-1:0] m0_adr, m1_adr;
  logic          m0_we, m1_we;
  logic [3:0]    m0_sel, m1_sel;
  logic [31:0]   m0_wdat, m1_wdat;
  logic [31:0]   m0_rdat, m1_rdat;
  logic          m0_ack, m1_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_wdat;
  logic [7:0]    mem_rdata;

  logic [7:0]    mem    [0:(1<<AW)-1];
  logic [7:0]    shadow [0:(1<<AW)-1];

  mem_op_t       trace_q[$];
  logic [31:0]   exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_byte_seq #(.AW(AW)) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_m0_cyc  (m0_cyc),
    .i_m0_adr  (m0_adr),
    .i_m0_we   (m0_we),
    .i_m0_sel  (m0_sel),
    .i_m0_dat  (m0_wdat),
    .o_m0_dat  (m0_rdat),
    .o_m0_ack  (m0_ack),
    .i_m1_cyc  (m1_cyc),
    .i_m1_adr  (m1_adr),
    .i_m1_we   (m1_we),
    .i_m1_sel  (m1_sel),
    .i_m1_dat  (m1_wdat),
    .o_m1_dat  (m1_rdat),
    .o_m1_ack  (m1_ack),
    .o_mem_en  (mem_en),
    .o_mem_we  (mem_we),
    .o_mem_adr (mem_adr),
    .o_mem_dat (mem_wdat),
    .i_mem_dat (mem_rdata)
  );

  // Byte memory with one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_adr] <= mem_wdat;
      else        mem_rdata    <= mem[mem_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input logic cyc, input logic [AW-1:0] adr,
                       input logic we, input logic [3:0] sel, input logic [31:0] dat);
    if (port) begin
      m1_cyc = cyc; m1_adr = adr; m1_we = we; m1_sel = sel; m1_wdat = dat;
    end else begin
      m0_cyc = cyc; m0_adr = adr; m0_we = we; m0_sel = sel; m0_wdat = dat;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One request on one port. drop_k > 0 releases cyc after that XFER cycle;
  // rst_k > 0 asserts reset during that XFER cycle and expects an abort.
  task automatic do_req(input string name, input bit port, input logic [AW-1:0] adr,
                        input logic we, input logic [3:0] sel, input logic [31:0] dat,
                        input int drop_k, input int rst_k);
    logic [AW-1:0] base;
    logic [31:0]   exp_rd;
    mem_op_t       op;
    int            n;
    bit            got_ack;
    bit            done;
    logic          my_ack, other_ack;
    base   = {adr[AW-1:2], 2'b00};
    n      = 0;
    exp_rd = 32'h0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) begin
        op.adr = base + AW'(3 - i);
        op.we  = we;
        op.dat = dat[i*8 +: 8];
        trace_q.push_back(op);
        if (we) begin
          if (rst_k == 0 || n < rst_k) shadow[op.adr] = op.dat;
        end else begin
          exp_rd[i*8 +: 8] = shadow[op.adr];
        end
        n++;
      end
    end
    exp_q.push_back(exp_rd);

    @(posedge clk); #1;
    drive(port, 1'b1, adr, we, sel, dat);
    got_ack = 1'b0;
    done    = 1'b0;
    for (int k = 1; k <= n + 6 && !done; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        if (trace_q.size() == 0) begin
          chk({name, "_extra_mem_cycle"}, {18'h0, mem_adr}, 32'hFFFF_FFFF);
        end else begin
          op = trace_q.pop_front();
          chk({name, "_mem_adr"}, {18'h0, mem_adr}, {18'h0, op.adr});
          chk({name, "_mem_we"},  {31'h0, mem_we},  {31'h0, op.we});
          chk({name, "_mem_dat"}, {24'h0, mem_wdat}, {24'h0, op.dat});
        end
      end
      my_ack    = port ? m1_ack : m0_ack;
      other_ack = port ? m0_ack : m1_ack;
      if (rst_k != 0 && k == rst_k + 1) begin
        chk({name, "_rst_mem_en"}, {31'h0, mem_en}, 32'h0);
        chk({name, "_rst_acks"}, {30'h0, m1_ack, m0_ack}, 32'h0);
        rst_n = 1'b1;
        trace_q.delete();
        exp_q.delete();
        done = 1'b1;
      end else if (my_ack) begin
        got_ack = 1'b1;
        done    = 1'b1;
        chk({name, "_ack_cycle"}, k, n + 2);
        chk({name, "_other_ack"}, {31'h0, other_ack}, 32'h0);
        chk({name, "_rdata"}, port ? m1_rdat : m0_rdat, exp_q.pop_front());
        drive(port, 1'b0, '0, 1'b0, 4'h0, 32'h0);
      end
      if (k == drop_k) drive(port, 1'b0, '0, 1'b0, 4'h0, 32'h0);
      if (rst_k != 0 && k == rst_k) begin
        rst_n = 1'b0;
        drive(port, 1'b0, '0, 1'b0, 4'h0, 32'h0);
      end
    end
    if (rst_k == 0) begin
      chk({name, "_ack_seen"}, {31'h0, got_ack}, 32'h1);
      chk({name, "_lanes_left"}, trace_q.size(), 32'h0);
      @(posedge clk); #1;
      chk({name, "_ack_one_cycle"}, {30'h0, m1_ack, m0_ack}, 32'h0);
      trace_q.delete();
      exp_q.delete();
    end
  endtask

  // Both ports request continuously; grants must alternate starting with port 0.
  task automatic arb_test();
    bit   grant_q[$];
    int   cnt;
    bit   done;
    logic [31:0] exp0;
    exp0 = {shadow[14'h0100], shadow[14'h0101], shadow[14'h0102], shadow[14'h0103]};
    grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    cnt  = 0;
    done = 1'b0;
    drive(1'b0, 1'b1, 14'h0100, 1'b0, 4'b1111, 32'h0);
    drive(1'b1, 1'b1, 14'h0104, 1'b0, 4'b0000, 32'h0);
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack) begin
        chk("arb_single_ack", {31'h0, m0_ack & m1_ack}, 32'h0);
        chk("arb_order", {31'h0, m1_ack}, {31'h0, grant_q.pop_front()});
        if (m0_ack) chk("arb_m0_rdata", m0_rdat, exp0);
        cnt++;
        if (cnt == 4) begin
          drive(1'b0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
          drive(1'b1, 1'b0, '0, 1'b0, 4'h0, 32'h0);
          done = 1'b1;
        end
      end
    end
    chk("arb_ack_count", cnt, 32'd4);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    <= 8'(i * 7 + 8'h5A);
      shadow[i]  = 8'(i * 7 + 8'h5A);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_ack",  {31'h0, m0_ack}, 32'h0);
    chk("rst_m1_ack",  {31'h0, m1_ack}, 32'h0);
    chk("rst_mem_en",  {31'h0, mem_en}, 32'h0);
    chk("rst_mem_adr", {18'h0, mem_adr}, 32'h0);
    chk("rst_mem_dat", {24'h0, mem_wdat}, 32'h0);
    chk("rst_rdata",   m0_rdat, 32'h0);
    rst_n = 1'b1;

    do_req("wr_word",   1'b1, 14'h0100, 1'b1, 4'b1111, 32'hDEADBEEF, 0, 0);
    do_req("rd_word",   1'b0, 14'h0100, 1'b0, 4'b1111, 32'h0,        0, 0);
    do_req("wr_byte",   1'b1, 14'h0105, 1'b1, 4'b0010, 32'h0000AB00, 0, 0);
    do_req("rd_merge",  1'b0, 14'h0104, 1'b0, 4'b1111, 32'h0,        0, 0);
    do_req("rd_sparse", 1'b1, 14'h0302, 1'b0, 4'b1010, 32'h0,        0, 0);
    do_req("rd_nosel",  1'b0, 14'h0100, 1'b0, 4'b0000, 32'h0,        0, 0);

    do_reset();
    arb_test();

    do_req("wr_rst",    1'b1, 14'h0200, 1'b1, 4'b1111, 32'h11223344, 0, 3);
    do_req("rd_rst",    1'b0, 14'h0200, 1'b0, 4'b1111, 32'h0,        0, 0);
    do_req("rd_drop",   1'b0, 14'h0100, 1'b0, 4'b1111, 32'h0,        1, 0);
    do_req("wr_top",    1'b1, 14'h3FFC, 1'b1, 4'b0001, 32'h000000A5, 0, 0);
    do_req("rd_top",    1'b0, 14'h3FFD, 1'b0, 4'b0011, 32'h0,        0, 0);
    do_req("wr_p0",     1'b0, 14'h0010, 1'b1, 4'b1001, 32'hC0FFEE77, 0, 0);
    do_req("rd_p1",     1'b1, 14'h0010, 1'b0, 4'b1111, 32'h0,        0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
